// File: rtl/fir_out_requant.sv
// fir_out_requant: round/shift/saturate FIR results into a narrower word behind a 2-entry skid buffer; stats built only with FIR_OUT_REQUANT_STATS_EN
module fir_out_requant #(
  parameter int pDATA_WIDTH = 32,
  parameter int pOUT_WIDTH  = 16,
  parameter int pSHIFT      = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pOUT_WIDTH-1:0]  m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  input  logic [31:0]            cfg_len,
  input  logic                   stat_clr,
  output logic [15:0]            sat_cnt,
  output logic                   len_err
);
  localparam int SW = pDATA_WIDTH + 1;
  localparam logic [SW-1:0] RND = SW'((pSHIFT > 0) ? (64'd1 << (pSHIFT - 1)) : 64'd0);
  localparam logic signed [SW-1:0] Q_MAX = SW'((64'sd1 <<< (pOUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] Q_MIN = ~Q_MAX;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nxt;
  logic signed [SW-1:0] sum, q;
  logic sat;
  logic [pOUT_WIDTH-1:0] q_out, skid_data;
  logic skid_last, push, pop, load_in, load_skid_out, load_skid;
  assign push = s_tvalid & s_tready;
  assign pop = m_tvalid & m_tready;
  assign m_tvalid = state != EMPTY;
  // widened sum cannot overflow; arithmetic shift gives round-half-up
  always_comb begin
    sum = {s_tdata[pDATA_WIDTH-1], s_tdata} + RND;
    q = sum >>> pSHIFT;
    sat = (q > Q_MAX) || (q < Q_MIN);
    q_out = (q > Q_MAX) ? {1'b0, {(pOUT_WIDTH-1){1'b1}}} :
            (q < Q_MIN) ? {1'b1, {(pOUT_WIDTH-1){1'b0}}} : q[pOUT_WIDTH-1:0];
  end
  // occupancy transitions and which register loads on this edge
  always_comb begin
    state_nxt = state;
    load_in = 1'b0;
    load_skid_out = 1'b0;
    load_skid = 1'b0;
    case (state)
      EMPTY: begin
        state_nxt = push ? ONE : EMPTY;
        load_in = push;
      end
      ONE: begin
        state_nxt = (push && !pop) ? FULL : (!push && pop) ? EMPTY : ONE;
        load_in = push && pop;
        load_skid = push && !pop;
      end
      FULL: begin
        state_nxt = pop ? ONE : FULL;
        load_skid_out = pop;
      end
      default: state_nxt = EMPTY;
    endcase
  end
  // occupancy register; s_tready is derived from the next occupancy so it never sees m_tready combinationally
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      state <= EMPTY;
      s_tready <= 1'b0;
    end else begin
      state <= state_nxt;
      s_tready <= state_nxt != FULL;
    end
  // output register and skid entry
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      m_tdata <= '0;
      m_tlast <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      if (load_in) {m_tlast, m_tdata} <= {s_tlast, q_out};
      else if (load_skid_out) {m_tlast, m_tdata} <= {skid_last, skid_data};
      if (load_skid) {skid_last, skid_data} <= {s_tlast, q_out};
    end
`ifdef FIR_OUT_REQUANT_STATS_EN
  logic [31:0] frm_cnt, frm_len, cur_len, nxt_cnt;
  logic len_bad;
  // frame length in force is cfg_len on the first beat, the latched value after
  always_comb begin
    cur_len = (frm_cnt == '0) ? cfg_len : frm_len;
    nxt_cnt = frm_cnt + 32'd1;
    len_bad = (cur_len != '0) && (s_tlast ? (nxt_cnt != cur_len) : (nxt_cnt == cur_len));
  end
  // frame counter and sticky statistics; clear beats a same-cycle update
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      frm_cnt <= '0;
      frm_len <= '0;
      sat_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (push) begin
        frm_cnt <= s_tlast ? '0 : nxt_cnt;
        frm_len <= cur_len;
      end
      sat_cnt <= stat_clr ? '0 : (push && sat && sat_cnt != 16'hFFFF) ? sat_cnt + 16'd1 : sat_cnt;
      len_err <= stat_clr ? 1'b0 : len_err | (push & len_bad);
    end
`else
  logic unused_stats;
  assign unused_stats = ^{cfg_len, stat_clr, sat};
  assign sat_cnt = '0;
  assign len_err = 1'b0;
`endif
endmodule
